// File: rtl/exp_sequencer.sv
// Exception / interrupt sequencer: capture, flush, dispatch, handler tracking.
// Optional double-fault halt enabled by defining EXP_DOUBLE_FAULT_EN.
module exp_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        v_ro,
    input  logic        dc_exp,
    input  logic        dc_prot_exp,
    input  logic        dc_page_fault,
    input  logic [31:0] fault_addr,
    input  logic [31:0] ro_eip,
    input  logic        int_req,
    input  logic        drain_done,
    input  logic        iret_done,
    output logic        exp_flush,
    output logic        isr_start,
    output logic        isr,
    output logic [7:0]  exp_vector,
    output logic [31:0] exp_eip,
    output logic [31:0] exp_cr2,
    output logic        double_fault
);

    localparam logic [7:0] VEC_DF   = 8'h08;
    localparam logic [7:0] VEC_PROT = 8'h0D;
    localparam logic [7:0] VEC_PF   = 8'h0E;
    localparam logic [7:0] VEC_INT  = 8'h20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_DISPATCH,
        S_IN_ISR
`ifdef EXP_DOUBLE_FAULT_EN
        , S_DF_HALT
`endif
    } state_t;

    state_t      r_state;
    logic        r_flush;
    logic        r_isr_start;
    logic        r_isr;
    logic [7:0]  r_vector;
    logic [31:0] r_eip;
    logic [31:0] r_cr2;

    logic        w_prot;
    logic        w_pf;
    logic        w_take;
    logic [7:0]  w_vec;

    // Exception sub-causes only count for a valid read-operands instruction
    always_comb begin
        w_prot = v_ro & dc_exp & dc_prot_exp;
        w_pf   = v_ro & dc_exp & dc_page_fault;
        w_take = w_prot | w_pf | int_req;
        w_vec  = VEC_INT;
        if (w_prot) begin
            w_vec = VEC_PROT;
        end else if (w_pf) begin
            w_vec = VEC_PF;
        end
    end

`ifdef EXP_DOUBLE_FAULT_EN
    logic r_df;
    logic w_df_take;

    // A page fault while the handler runs escalates to a double fault
    always_comb begin
        w_df_take = v_ro & dc_page_fault;
    end

    assign double_fault = r_df;
`else
    assign double_fault = 1'b0;
`endif

    // Sequencer FSM; every output is a register updated here
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_flush     <= 1'b0;
            r_isr_start <= 1'b0;
            r_isr       <= 1'b0;
            r_vector    <= 8'h00;
            r_eip       <= 32'h0;
            r_cr2       <= 32'h0;
`ifdef EXP_DOUBLE_FAULT_EN
            r_df        <= 1'b0;
`endif
        end else begin
            r_isr_start <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_state  <= S_FLUSH;
                        r_flush  <= 1'b1;
                        r_vector <= w_vec;
                        r_eip    <= ro_eip;
                        if (w_vec == VEC_PF) begin
                            r_cr2 <= fault_addr;
                        end
                    end
                end
                S_FLUSH: begin
                    if (drain_done) begin
                        r_state     <= S_DISPATCH;
                        r_flush     <= 1'b0;
                        r_isr_start <= 1'b1;
                        r_isr       <= 1'b1;
                    end
                end
                S_DISPATCH: begin
                    r_state <= S_IN_ISR;
                end
                S_IN_ISR: begin
`ifdef EXP_DOUBLE_FAULT_EN
                    if (w_df_take) begin
                        r_state  <= S_DF_HALT;
                        r_vector <= VEC_DF;
                        r_df     <= 1'b1;
                    end else if (iret_done) begin
                        r_state <= S_IDLE;
                        r_isr   <= 1'b0;
                    end
`else
                    if (iret_done) begin
                        r_state <= S_IDLE;
                        r_isr   <= 1'b0;
                    end
`endif
                end
`ifdef EXP_DOUBLE_FAULT_EN
                S_DF_HALT: begin
                    r_state <= S_DF_HALT;
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_flush <= 1'b0;
                    r_isr   <= 1'b0;
                end
            endcase
        end
    end

    assign exp_flush  = r_flush;
    assign isr_start  = r_isr_start;
    assign isr        = r_isr;
    assign exp_vector = r_vector;
    assign exp_eip    = r_eip;
    assign exp_cr2    = r_cr2;

endmodule

// File: tb/tb_exp_sequencer.sv
// Scoreboard bench for exp_sequencer with a priority-rule reference model.
// Define EXP_DOUBLE_FAULT_EN for both files to cover the double-fault build.
module tb_exp_sequencer;

    logic        clk;
    logic        rst_n;
    logic        v_ro;
    logic        dc_exp;
    logic        dc_prot_exp;
    logic        dc_page_fault;
    logic [31:0] fault_addr;
    logic [31:0] ro_eip;
    logic        int_req;
    logic        drain_done;
    logic        iret_done;
    logic        exp_flush;
    logic        isr_start;
    logic        isr;
    logic [7:0]  exp_vector;
    logic [31:0] exp_eip;
    logic [31:0] exp_cr2;
    logic        double_fault;

    typedef struct {
        logic [7:0]  vec;
        logic [31:0] eip;
        logic [31:0] cr2;
        int          flen;
    } exp_t;

    exp_t        sbq[$];
    logic [31:0] m_cr2;
    int          n_vec;
    int          n_err;
    int          flush_cnt;

    exp_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .v_ro         (v_ro),
        .dc_exp       (dc_exp),
        .dc_prot_exp  (dc_prot_exp),
        .dc_page_fault(dc_page_fault),
        .fault_addr   (fault_addr),
        .ro_eip       (ro_eip),
        .int_req      (int_req),
        .drain_done   (drain_done),
        .iret_done    (iret_done),
        .exp_flush    (exp_flush),
        .isr_start    (isr_start),
        .isr          (isr),
        .exp_vector   (exp_vector),
        .exp_eip      (exp_eip),
        .exp_cr2      (exp_cr2),
        .double_fault (double_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", nm, act, req);
        end
    endtask

    task automatic clr_in();
        v_ro = 0; dc_exp = 0; dc_prot_exp = 0; dc_page_fault = 0;
        int_req = 0; iret_done = 0; drain_done = 0;
    endtask

    // Random noise; allow_pf / allow_iret gate sources that must stay quiet
    task automatic junk(input bit allow_pf, input bit allow_iret);
        v_ro          = 1'($urandom);
        dc_exp        = 1'($urandom);
        dc_prot_exp   = 1'($urandom);
        dc_page_fault = allow_pf ? 1'($urandom) : 1'b0;
        int_req       = 1'($urandom);
        iret_done     = allow_iret ? 1'($urandom) : 1'b0;
        fault_addr    = $urandom;
        ro_eip        = $urandom;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_flush"}, 32'(exp_flush), 0);
        chk({nm, "_isr_start"}, 32'(isr_start), 0);
        chk({nm, "_isr"}, 32'(isr), 0);
        chk({nm, "_df"}, 32'(double_fault), 0);
        chk({nm, "_vec"}, 32'(exp_vector), 0);
        chk({nm, "_eip"}, exp_eip, 0);
        chk({nm, "_cr2"}, exp_cr2, 0);
    endtask

    // Present one stimulus in IDLE and walk it through to handler exit
    task automatic txn(input logic v, input logic e, input logic p,
                       input logic f, input logic ir,
                       input logic [31:0] fa, input logic [31:0] eip,
                       input int d, input int hold, input bit df);
        exp_t x;
        bit   fire;
        bit   seen;
        int   lat;
        v_ro = v; dc_exp = e; dc_prot_exp = p; dc_page_fault = f;
        int_req = ir; fault_addr = fa; ro_eip = eip;
        drain_done = 0; iret_done = 0;
        fire = (v & e & (p | f)) | ir;
        if (fire) begin
            if (v & e & p) x.vec = 8'h0D;
            else if (v & e & f) x.vec = 8'h0E;
            else x.vec = 8'h20;
            if (x.vec == 8'h0E) m_cr2 = fa;
            x.eip  = eip;
            x.cr2  = m_cr2;
            x.flen = d + 1;
            sbq.push_back(x);
        end
        step();
        if (!fire) begin
            chk("ignored_no_flush", 32'(exp_flush), 0);
            clr_in();
            iret_done = 1;
            step();
            iret_done = 0;
            chk("stray_iret_isr", 32'(isr), 0);
            return;
        end
        chk("flush_entry", 32'(exp_flush), 1);
        lat = 1;
        repeat (d) begin
            junk(1'b1, 1'b1);
            step();
            lat++;
        end
        junk(1'b1, 1'b1);
        drain_done = 1;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            lat++;
            if (isr_start) begin
                seen = 1;
                break;
            end
        end
        if (seen) chk("isr_start_latency", 32'(lat), 32'(d + 2));
        else chk("isr_start_timeout", 32'(seen), 1);
        drain_done = 0;
`ifdef EXP_DOUBLE_FAULT_EN
        junk(1'b0, 1'b0);
`else
        junk(1'b1, 1'b0);
`endif
        step();
        repeat (hold) begin
            chk("isr_held", 32'(isr), 1);
`ifdef EXP_DOUBLE_FAULT_EN
            junk(1'b0, 1'b0);
`else
            junk(1'b1, 1'b0);
`endif
            step();
        end
        clr_in();
        if (df) begin
            v_ro = 1; dc_exp = 1; dc_page_fault = 1;
            fault_addr = $urandom;
            step();
            clr_in();
`ifdef EXP_DOUBLE_FAULT_EN
            chk("df_set", 32'(double_fault), 1);
            chk("df_vec", 32'(exp_vector), 32'h08);
            iret_done = 1;
            step();
            iret_done = 0;
            repeat (3) begin
                drain_done = 1;
                step();
                chk("df_held", 32'(double_fault), 1);
            end
            drain_done = 0;
            #2 rst_n = 0;
            #1 chk("df_reset", 32'(double_fault), 0);
            m_cr2 = 0;
            step();
            rst_n = 1;
            step();
            return;
`else
            chk("pf_in_isr_no_df", 32'(double_fault), 0);
            chk("pf_in_isr_vec", 32'(exp_vector), 32'(x.vec));
            chk("pf_in_isr_isr", 32'(isr), 1);
`endif
        end
        iret_done = 1;
        step();
        iret_done = 0;
        chk("isr_clear", 32'(isr), 0);
        chk("idle_no_flush", 32'(exp_flush), 0);
        iret_done = 1;
        step();
        iret_done = 0;
        chk("stray_iret_idle", 32'(isr), 0);
    endtask

    // Monitor: score every isr_start against the queued expectation
    initial begin
        flush_cnt = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                flush_cnt = 0;
            end else begin
                if (exp_flush) flush_cnt++;
                if (isr_start) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_isr_start", 32'(isr_start), 0);
                    end else begin
                        exp_t x;
                        x = sbq.pop_front();
                        chk("sb_vector", 32'(exp_vector), 32'(x.vec));
                        chk("sb_eip", exp_eip, x.eip);
                        chk("sb_cr2", exp_cr2, x.cr2);
                        chk("sb_flush_len", 32'(flush_cnt), 32'(x.flen));
                        chk("sb_isr", 32'(isr), 1);
                    end
                    flush_cnt = 0;
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec = 0;
        n_err = 0;
        m_cr2 = 0;
        rst_n = 0;
        clr_in();
        fault_addr = 0;
        ro_eip = 0;
        #12;
        chk_reset_vals("reset");
        step();
        rst_n = 1;
        step();

        // Page fault, immediate drain
        txn(1, 1, 0, 1, 0, 32'h0040_1FFC, 32'h0000_1234, 0, 2, 0);
        // All three sources together: protection wins, CR2 kept
        txn(1, 1, 1, 1, 1, 32'hDEAD_BEEF, 32'h0000_5678, 0, 1, 0);
        // Slow drain
        txn(1, 1, 0, 0, 1, 32'h1111_2222, 32'h0000_9ABC, 5, 1, 0);
        // dc_exp with no valid instruction is ignored
        txn(0, 1, 1, 1, 0, 32'h3333_4444, 32'h0000_0BAD, 0, 0, 0);

        // Reset in the middle of FLUSH
        v_ro = 1; dc_exp = 1; dc_page_fault = 1;
        fault_addr = 32'hCAFE_0000; ro_eip = 32'h0000_7777;
        step();
        clr_in();
        chk("rst_flush_entry", 32'(exp_flush), 1);
        #2 rst_n = 0;
        #1 chk_reset_vals("async_rst");
        m_cr2 = 0;
        drain_done = 1;
        step();
        rst_n = 1;
        repeat (5) begin
            step();
            chk("no_isr_start_after_rst", 32'(isr_start), 0);
            chk("no_flush_after_rst", 32'(exp_flush), 0);
        end
        drain_done = 0;

        // Page fault while the handler runs
        txn(1, 1, 1, 0, 0, 32'h5555_6666, 32'h0000_4321, 1, 1, 1);

        for (int i = 0; i < 40; i++) begin
            txn(1'($urandom_range(0, 3) != 0), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom),
                $urandom, $urandom,
                $urandom_range(0, 4), $urandom_range(0, 3), 1'b0);
        end

        repeat (3) step();
        chk("sb_drained", 32'(sbq.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
